// File: rtl/conv_pkg.sv
// conv_pkg: window type and element indexing shared by the window producer and inner-product units
package conv_pkg;

    localparam int D_WIDTH_DEF = 8;
    localparam int K_DEF       = 5;

    // Packed KxK window; element i = r*K + c sits at bits [D_WIDTH*i +: D_WIDTH]
    typedef logic [D_WIDTH_DEF*K_DEF*K_DEF-1:0] window_t;

    // Flat element index of window row r, column c for a kernel of side k
    function automatic int idx(input int r, input int c, input int k);
        return r * k + c;
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// conv_line_buffer: K-1 chained row delay lines exposing the same-column pixel of each buffered row
module conv_line_buffer #(
    parameter int D_WIDTH   = 8,
    parameter int IMG_WIDTH = 28,
    parameter int K         = 5
) (
    input  logic                     clk,
    input  logic                     shift_en,
    input  logic [D_WIDTH-1:0]       in_data,
    output logic [D_WIDTH*(K-1)-1:0] taps
);

    localparam int DEPTH = (K - 1) * IMG_WIDTH;

    // Element 0 is the newest pixel; element n is the pixel accepted n shifts ago
    logic [D_WIDTH*DEPTH-1:0] sr_q, sr_d;

    // Advance the whole chain by one pixel per accepted input
    always_comb begin
        sr_d = shift_en ? {sr_q[D_WIDTH*(DEPTH-1)-1:0], in_data} : sr_q;
    end

    // Contents are don't-care after reset, so the delay lines carry no reset
    always_ff @(posedge clk) begin
        sr_q <= sr_d;
    end

    // Tap j feeds window row j: the pixel (K-1-j) rows above the incoming one
    for (genvar j = 0; j < K - 1; j++) begin : g_tap
        assign taps[D_WIDTH*j +: D_WIDTH] = sr_q[D_WIDTH*((K-1-j)*IMG_WIDTH-1) +: D_WIDTH];
    end

endmodule

// File: rtl/conv_window_generator.sv
// conv_window_generator: turns a raster pixel stream into a stream of packed KxK windows
module conv_window_generator
    import conv_pkg::*;
#(
    parameter int D_WIDTH    = 8,
    parameter int IMG_WIDTH  = 28,
    parameter int IMG_HEIGHT = 28,
    parameter int K          = 5
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [D_WIDTH-1:0]            in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [D_WIDTH*K*K-1:0]        out_window,
    output logic [$clog2(IMG_HEIGHT)-1:0] out_row,
    output logic [$clog2(IMG_WIDTH)-1:0]  out_col,
    output logic                          out_last
);

    localparam int WW = D_WIDTH * K * K;
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_HEIGHT - 1);
    localparam logic [RW-1:0] ROW_MIN = RW'(K - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0] COL_MIN = CW'(K - 1);

    logic [D_WIDTH*(K-1)-1:0] taps;
    logic                     accept, complete;
    logic [WW-1:0]            win_q, win_d, out_window_q, out_window_d;
    logic [RW-1:0]            row_q, row_d, out_row_q, out_row_d;
    logic [CW-1:0]            col_q, col_d, out_col_q, out_col_d;
    logic                     out_valid_q, out_valid_d, out_last_q, out_last_d;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    // Only pixels that close a full KxK neighbourhood inside one row publish a window
    assign complete = accept && row_q >= ROW_MIN && col_q >= COL_MIN;

    conv_line_buffer #(
        .D_WIDTH   (D_WIDTH),
        .IMG_WIDTH (IMG_WIDTH),
        .K         (K)
    ) u_line_buffer (
        .clk      (clk),
        .shift_en (accept),
        .in_data  (in_data),
        .taps     (taps)
    );

    // Shift the window one column left and insert the new right column from taps plus the fresh pixel
    always_comb begin
        win_d = win_q;
        if (accept) begin
            win_d = win_q >> D_WIDTH;
            for (int r = 0; r < K - 1; r++)
                win_d[D_WIDTH*idx(r, K-1, K) +: D_WIDTH] = taps[D_WIDTH*r +: D_WIDTH];
            win_d[D_WIDTH*idx(K-1, K-1, K) +: D_WIDTH] = in_data;
        end
    end

    // Raster position of the next pixel and the output register load/clear
    always_comb begin
        col_d        = !accept ? col_q : (col_q == COL_MAX) ? '0 : col_q + CW'(1);
        row_d        = (!accept || col_q != COL_MAX) ? row_q : (row_q == ROW_MAX) ? '0 : row_q + RW'(1);
        out_valid_d  = complete || (out_valid_q && !out_ready);
        out_window_d = complete ? win_d : out_window_q;
        out_row_d    = complete ? row_q - ROW_MIN : out_row_q;
        out_col_d    = complete ? col_q - COL_MIN : out_col_q;
        out_last_d   = complete ? (row_q == ROW_MAX && col_q == COL_MAX) : out_last_q;
    end

    // State registers; reset drops any partial frame so the next pixel is (0,0)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q        <= '0;
            row_q        <= '0;
            col_q        <= '0;
            out_valid_q  <= 1'b0;
            out_window_q <= '0;
            out_row_q    <= '0;
            out_col_q    <= '0;
            out_last_q   <= 1'b0;
        end else begin
            win_q        <= win_d;
            row_q        <= row_d;
            col_q        <= col_d;
            out_valid_q  <= out_valid_d;
            out_window_q <= out_window_d;
            out_row_q    <= out_row_d;
            out_col_q    <= out_col_d;
            out_last_q   <= out_last_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_window = out_window_q;
    assign out_row    = out_row_q;
    assign out_col    = out_col_q;
    assign out_last   = out_last_q;

endmodule

// File: tb/tb_conv_window_generator.sv
// tb_conv_window_generator: random and directed stimulus checked against an image-array reference model
module tb_conv_window_generator;

    localparam int D  = 8;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int K  = 3;
    localparam int WW = D * K * K;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b1;
    logic [D-1:0]  in_data = '0;
    logic          in_ready, out_valid, out_last;
    logic [WW-1:0] out_window;
    logic [1:0]    out_row, out_col;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    conv_window_generator #(
        .D_WIDTH    (D),
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .K          (K)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_window (out_window),
        .out_row    (out_row),
        .out_col    (out_col),
        .out_last   (out_last)
    );

    task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: the frame as a 2-D image; windows are read straight out of it
    logic [D-1:0]  img [H][W];
    int            prow = 0, pcol = 0, m_row = 0, m_col = 0;
    bit            m_valid = 0, m_last = 0, m_acc;
    logic [WW-1:0] m_win = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prow = 0; pcol = 0; m_valid = 0; m_last = 0; m_row = 0; m_col = 0;
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_window", out_window, 0);
            chk("rst_out_pos", {out_row, out_col}, 0);
            chk("rst_out_last", out_last, 0);
            chk("rst_in_ready", in_ready, 1);
        end else begin
            chk("in_ready", in_ready, !m_valid || out_ready);
            chk("out_valid", out_valid, m_valid);
            if (m_valid) begin
                chk("out_window", out_window, m_win);
                chk("out_row", out_row, m_row);
                chk("out_col", out_col, m_col);
                chk("out_last", out_last, m_last);
            end
            m_acc = in_valid && (!m_valid || out_ready);
            if (m_valid && out_ready) m_valid = 0;
            if (m_acc) begin
                img[prow][pcol] = in_data;
                if (prow >= K - 1 && pcol >= K - 1) begin
                    for (int r = 0; r < K; r++)
                        for (int c = 0; c < K; c++)
                            m_win[D*(r*K+c) +: D] = img[prow-K+1+r][pcol-K+1+c];
                    m_valid = 1;
                    m_row = prow - K + 1;
                    m_col = pcol - K + 1;
                    m_last = (prow == H - 1 && pcol == W - 1);
                end
                pcol++;
                if (pcol == W) begin
                    pcol = 0;
                    prow = (prow + 1) % H;
                end
            end
        end
    end

    // Log of windows actually handed downstream, for the directed literal checks
    logic [WW-1:0] cap_w [$];
    int            cap_rc [$];
    bit            cap_l [$];

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            cap_w.push_back(out_window);
            cap_rc.push_back(out_row * 4 + out_col);
            cap_l.push_back(out_last);
        end
    end

    task automatic clear_caps();
        cap_w.delete();
        cap_rc.delete();
        cap_l.delete();
    endtask

    // vmode: 0 always valid, 1 toggling, 2 random; rmode: 0 ready, 1 five-cycle stall, 2 random, 3 never ready
    task automatic feed(input int npix, input int vmode, input int rmode, input bit rnd);
        int sent = 0;
        int cyc = 0;
        while (sent < npix) begin
            @(posedge clk);
            #1;
            in_valid  = (vmode == 0) ? 1'b1 : (vmode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            out_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? !(cyc >= 11 && cyc < 16) :
                        (rmode == 2) ? ($urandom_range(0, 3) != 0) : 1'b0;
            in_data   = rnd ? D'($urandom) : D'(sent % 16);
            #3;
            if (rmode == 1 && cyc >= 11 && cyc < 16) chk("stall_in_ready", in_ready, 0);
            if (in_valid && in_ready) sent++;
            cyc++;
            if (cyc > npix * 20 + 200) begin
                vectors++;
                miscompares++;
                $display("FAIL feed_timeout: got %0d pixels accepted expected %0d", sent, npix);
                break;
            end
        end
    endtask

    task automatic drain();
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("reset_async_out_valid", out_valid, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Hand-computed windows of a 4x4 frame with pixel = row*4+col
    task automatic check_caps(input int base);
        logic [WW-1:0] ew [4];
        int            erc [4];
        ew  = '{72'h0a0908060504020100, 72'h0b0a09070605030201,
                72'h0e0d0c0a0908060504, 72'h0f0e0d0b0a09070605};
        erc = '{0, 1, 4, 5};
        for (int i = 0; i < 4; i++) begin
            if (base + i < cap_w.size()) begin
                chk("lit_window", cap_w[base+i], ew[i]);
                chk("lit_pos", cap_rc[base+i], erc[i]);
                chk("lit_last", cap_l[base+i], i == 3);
            end else begin
                vectors++;
                miscompares++;
                $display("FAIL lit_missing: got %0d windows expected %0d", cap_w.size(), base + 4);
            end
        end
    endtask

    initial begin
        int sum;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        // Single frame, full rate
        clear_caps();
        feed(16, 0, 0, 0);
        drain();
        chk("t1_count", cap_w.size(), 4);
        check_caps(0);
        sum = 0;
        if (cap_w.size() > 0)
            for (int i = 0; i < K * K; i++) sum += int'(cap_w[0][D*i +: D]);
        chk("t6_dot_all_ones", sum, 45);
        // Backpressure on the first window
        clear_caps();
        feed(16, 0, 1, 0);
        drain();
        chk("t3_count", cap_w.size(), 4);
        check_caps(0);
        // Gapped input
        clear_caps();
        feed(16, 1, 0, 0);
        drain();
        chk("t4_count", cap_w.size(), 4);
        check_caps(0);
        // Reset mid-frame, then a clean frame
        feed(10, 0, 0, 0);
        do_reset();
        clear_caps();
        feed(16, 0, 0, 0);
        drain();
        chk("t5_count", cap_w.size(), 4);
        check_caps(0);
        // Two contiguous frames
        clear_caps();
        feed(32, 0, 0, 0);
        drain();
        chk("t6_count", cap_w.size(), 8);
        check_caps(0);
        check_caps(4);
        // Reset while a window is held under backpressure
        feed(11, 0, 3, 0);
        do_reset();
        // Random traffic across frame boundaries with one reset mid-stream
        for (int i = 0; i < 8; i++) begin
            feed($urandom_range(10, 48), 2, 2, 1);
            if (i == 3) do_reset();
        end
        drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
